// File: rtl/text_console_ctrl.sv
// text_console_ctrl: turns an ASCII byte stream into single-cycle write
// transactions on the character map (and optionally the colour map),
// keeping a cursor and clearing rows/the screen with bursts of spaces.
// Optional feature macro: TEXT_CONSOLE_COLOR_EN adds a colour-map attribute
// write after every printable character.
module text_console_ctrl #(
   parameter int unsigned COLS      = 80,
   parameter int unsigned ROWS      = 30,
   parameter logic [31:0] CHAR_BASE = 32'h0000_0000,
   parameter logic [31:0] COL_BASE  = 32'h0000_1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ch_valid_i,
   input  logic [7:0]  ch_data_i,
   input  logic [7:0]  ch_attr_i,
   output logic        ch_ready_o,
   output logic        req_o,
   output logic        write_enable_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] addr_o,
   output logic [31:0] write_data_o,
   output logic [6:0]  cur_col_o,
   output logic [4:0]  cur_row_o,
   output logic        busy_o
);

   localparam int unsigned ROW_WORDS = COLS / 4;
   localparam int unsigned ALL_WORDS = (COLS * ROWS) / 4;
   localparam int unsigned CNT_W     = $clog2(ALL_WORDS + 1);
   localparam logic [31:0] SPACES    = 32'h2020_2020;

   typedef enum logic [2:0] {
      IDLE,
      PUT_CHAR,
`ifdef TEXT_CONSOLE_COLOR_EN
      PUT_ATTR,
`endif
      CLR_ROW,
      CLR_ALL
   } state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [6:0]         col_n;
   logic [4:0]         row_n;
   logic [4:0]         row_inc;
   logic [11:0]        off;
   logic [31:0]        word_off;
   logic [3:0]         be_c;
   logic               printable;
   logic               accept;
   logic               advance;
   logic               row_clr;
   logic               req_n;
   logic [3:0]         be_n;
   logic [31:0]        addr_n;
   logic [31:0]        data_n;
   logic               ready_n;
   logic               busy_n;

`ifdef TEXT_CONSOLE_COLOR_EN
   logic [7:0]         attr_q, attr_n;
`else
   logic               unused_attr;
   assign unused_attr = ^ch_attr_i;
`endif

   // Cursor-derived byte offset and the byte-lane addressing it implies.
   assign off       = 12'(32'(cur_row_o) * COLS + 32'(cur_col_o));
   assign word_off  = 32'({off[11:2], 2'b00});
   assign be_c      = 4'b0001 << off[1:0];
   assign row_inc   = (cur_row_o == 5'(ROWS - 1)) ? 5'd0 : cur_row_o + 5'd1;
   assign printable = (ch_data_i >= 8'h20) && (ch_data_i <= 8'h7E);
   assign accept    = ch_valid_i && ch_ready_o;

   // Next-state, cursor update and next bus-write computation.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      col_n   = cur_col_o;
      row_n   = cur_row_o;
      req_n   = 1'b0;
      be_n    = 4'h0;
      addr_n  = 32'h0;
      data_n  = 32'h0;
      advance = 1'b0;
      row_clr = 1'b0;
`ifdef TEXT_CONSOLE_COLOR_EN
      attr_n  = attr_q;
`endif

      case (state)
         IDLE: begin
            if (accept) begin
               if (printable) begin
                  state_n = PUT_CHAR;
                  req_n   = 1'b1;
                  be_n    = be_c;
                  addr_n  = CHAR_BASE + word_off;
                  data_n  = {4{ch_data_i}};
`ifdef TEXT_CONSOLE_COLOR_EN
                  attr_n  = ch_attr_i;
`endif
               end else begin
                  case (ch_data_i)
                     8'h0A: begin
                        col_n   = 7'd0;
                        row_n   = row_inc;
                        row_clr = 1'b1;
                     end
                     8'h0D: col_n = 7'd0;
                     8'h08: begin
                        if (cur_col_o != 7'd0) col_n = cur_col_o - 7'd1;
                     end
                     8'h0C: begin
                        col_n   = 7'd0;
                        row_n   = 5'd0;
                        state_n = CLR_ALL;
                        req_n   = 1'b1;
                        be_n    = 4'hF;
                        addr_n  = CHAR_BASE;
                        data_n  = SPACES;
                        cnt_n   = CNT_W'(1);
                     end
                     default: ;
                  endcase
               end
            end
         end
         PUT_CHAR: begin
`ifdef TEXT_CONSOLE_COLOR_EN
            state_n = PUT_ATTR;
            req_n   = 1'b1;
            be_n    = be_c;
            addr_n  = COL_BASE + word_off;
            data_n  = {4{attr_q}};
`else
            advance = 1'b1;
`endif
         end
`ifdef TEXT_CONSOLE_COLOR_EN
         PUT_ATTR: advance = 1'b1;
`endif
         CLR_ROW: begin
            if (cnt == CNT_W'(ROW_WORDS)) begin
               state_n = IDLE;
            end else begin
               req_n  = 1'b1;
               be_n   = 4'hF;
               addr_n = CHAR_BASE + 32'(cur_row_o) * COLS + 32'({cnt, 2'b00});
               data_n = SPACES;
               cnt_n  = cnt + CNT_W'(1);
            end
         end
         CLR_ALL: begin
            if (cnt == CNT_W'(ALL_WORDS)) begin
               state_n = IDLE;
            end else begin
               req_n  = 1'b1;
               be_n   = 4'hF;
               addr_n = CHAR_BASE + 32'({cnt, 2'b00});
               data_n = SPACES;
               cnt_n  = cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // Cursor advance after a printable character; wrapping clears the new row.
      if (advance) begin
         if (cur_col_o < 7'(COLS - 1)) begin
            col_n   = cur_col_o + 7'd1;
            state_n = IDLE;
         end else begin
            col_n   = 7'd0;
            row_n   = row_inc;
            row_clr = 1'b1;
         end
      end

      // Row clear starts immediately with word 0 so no bubble cycle is lost.
      if (row_clr) begin
         state_n = CLR_ROW;
         req_n   = 1'b1;
         be_n    = 4'hF;
         addr_n  = CHAR_BASE + 32'(row_n) * COLS;
         data_n  = SPACES;
         cnt_n   = CNT_W'(1);
      end

      ready_n = (state_n == IDLE);
      busy_n  = (state_n == CLR_ROW) || (state_n == CLR_ALL);
   end

   // State, cursor and registered bus outputs; reset restarts a full clear.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state          <= CLR_ALL;
         cnt            <= '0;
         cur_col_o      <= 7'd0;
         cur_row_o      <= 5'd0;
         req_o          <= 1'b0;
         write_enable_o <= 1'b0;
         mem_be_o       <= 4'h0;
         addr_o         <= 32'h0;
         write_data_o   <= 32'h0;
         ch_ready_o     <= 1'b0;
         busy_o         <= 1'b1;
`ifdef TEXT_CONSOLE_COLOR_EN
         attr_q         <= 8'h0;
`endif
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         cur_col_o      <= col_n;
         cur_row_o      <= row_n;
         req_o          <= req_n;
         write_enable_o <= req_n;
         mem_be_o       <= be_n;
         addr_o         <= addr_n;
         write_data_o   <= data_n;
         ch_ready_o     <= ready_n;
         busy_o         <= busy_n;
`ifdef TEXT_CONSOLE_COLOR_EN
         attr_q         <= attr_n;
`endif
      end
   end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Testbench for text_console_ctrl: reference cursor model feeding a queue of
// expected bus writes, drained by a monitor as the DUT issues them.
module tb_text_console_ctrl;

   localparam int unsigned COLS      = 80;
   localparam int unsigned ROWS      = 30;
   localparam logic [31:0] CHAR_BASE = 32'h0000_0000;
   localparam logic [31:0] COL_BASE  = 32'h0000_1000;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        ch_valid_i;
   logic [7:0]  ch_data_i;
   logic [7:0]  ch_attr_i;
   logic        ch_ready_o;
   logic        req_o;
   logic        write_enable_o;
   logic [3:0]  mem_be_o;
   logic [31:0] addr_o;
   logic [31:0] write_data_o;
   logic [6:0]  cur_col_o;
   logic [4:0]  cur_row_o;
   logic        busy_o;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_tests = 0;
   int  n_fail  = 0;
   int  nwr     = 0;
   int  mrow    = 0;
   int  mcol    = 0;
   int  base;

   text_console_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .CHAR_BASE(CHAR_BASE), .COL_BASE(COL_BASE)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .ch_valid_i(ch_valid_i), .ch_data_i(ch_data_i), .ch_attr_i(ch_attr_i),
      .ch_ready_o(ch_ready_o), .req_o(req_o), .write_enable_o(write_enable_o),
      .mem_be_o(mem_be_o), .addr_o(addr_o), .write_data_o(write_data_o),
      .cur_col_o(cur_col_o), .cur_row_o(cur_row_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      wr_t w;
      w.addr = a; w.be = be; w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic push_row_clear(input int row);
      for (int w = 0; w < int'(COLS / 4); w++)
         push_wr(CHAR_BASE + 32'(row * int'(COLS) + 4 * w), 4'hF, 32'h2020_2020);
   endtask

   task automatic push_all_clear();
      for (int w = 0; w < int'(COLS * ROWS / 4); w++)
         push_wr(CHAR_BASE + 32'(4 * w), 4'hF, 32'h2020_2020);
   endtask

   // Reference behaviour for one accepted byte.
   task automatic model_accept(input logic [7:0] b, input logic [7:0] a);
      int off;
      if (b >= 8'h20 && b <= 8'h7E) begin
         off = mrow * int'(COLS) + mcol;
         push_wr(CHAR_BASE + 32'(off - off % 4), 4'(1 << (off % 4)), {4{b}});
`ifdef TEXT_CONSOLE_COLOR_EN
         push_wr(COL_BASE + 32'(off - off % 4), 4'(1 << (off % 4)), {4{a}});
`endif
         if (mcol < int'(COLS) - 1) mcol++;
         else begin
            mcol = 0;
            mrow = (mrow + 1) % int'(ROWS);
            push_row_clear(mrow);
         end
      end else if (b == 8'h0A) begin
         mcol = 0;
         mrow = (mrow + 1) % int'(ROWS);
         push_row_clear(mrow);
      end else if (b == 8'h0D) begin
         mcol = 0;
      end else if (b == 8'h08) begin
         if (mcol > 0) mcol--;
      end else if (b == 8'h0C) begin
         mcol = 0;
         mrow = 0;
         push_all_clear();
      end
      if (a == 8'hFF) mcol = mcol;
   endtask

   task automatic send(input logic [7:0] b, input logic [7:0] a);
      int n = 0;
      @(negedge clk);
      ch_valid_i = 1'b1; ch_data_i = b; ch_attr_i = a;
      while (!ch_ready_o && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!ch_ready_o) check("send_ready_timeout", 32'(ch_ready_o), 32'd1);
      else model_accept(b, a);
      @(posedge clk);
      #1;
      ch_valid_i = 1'b0;
   endtask

   task automatic wait_ready(input int budget, input string tag);
      int n = 0;
      @(negedge clk);
      #1;
      while (!ch_ready_o && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_ready"}, 32'(ch_ready_o), 32'd1);
      check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_col"}, 32'(cur_col_o), 32'(mcol));
      check({tag, "_row"}, 32'(cur_row_o), 32'(mrow));
   endtask

   // Bus monitor: every issued write must match the next expected one.
   always @(negedge clk) begin
      if (rst_i === 1'b1 && req_o === 1'b1) begin
         nwr++;
         check("we_eq_req", 32'(write_enable_o), 32'd1);
         check("ready_low_during_write", 32'(ch_ready_o), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(req_o), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", addr_o, mon_e.addr);
            check("wr_be", 32'(mem_be_o), 32'(mon_e.be));
            check("wr_data", write_data_o, mon_e.data);
         end
      end
   end

   // Directed sequence.
   initial begin
      rst_i = 1'b1; ch_valid_i = 1'b0; ch_data_i = 8'h0; ch_attr_i = 8'h0;
      #1 rst_i = 1'b0;
      #2;
      check("rst_req", 32'(req_o), 32'd0);
      check("rst_we", 32'(write_enable_o), 32'd0);
      check("rst_be", 32'(mem_be_o), 32'd0);
      check("rst_addr", addr_o, 32'd0);
      check("rst_data", write_data_o, 32'd0);
      check("rst_col", 32'(cur_col_o), 32'd0);
      check("rst_row", 32'(cur_row_o), 32'd0);
      check("rst_ready", 32'(ch_ready_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd1);

      // Power-up clear.
      @(negedge clk);
      @(negedge clk);
      push_all_clear();
      rst_i = 1'b1;
      @(negedge clk);
      #1;
      check("first_clear_req", 32'(req_o), 32'd1);
      wait_ready(2000, "powerup");
      check("powerup_writes", 32'(nwr), 32'd600);
      check("powerup_busy", 32'(busy_o), 32'd0);

      // 'A' at (0,5).
      for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 8'h07);
      wait_ready(100, "pre_a");
      send(8'h41, 8'h1E);
      wait_ready(100, "a");
      check("a_col_lit", 32'(cur_col_o), 32'd6);
      check("a_row_lit", 32'(cur_row_o), 32'd0);

      // Line wrap at (3,79).
      send(8'h0D, 8'h00);
      for (int i = 0; i < 3; i++) send(8'h0A, 8'h00);
      for (int i = 0; i < 79; i++) send(8'h20 + 8'(i % 95), 8'h0F);
      wait_ready(200, "pre_wrap");
      check("pre_wrap_col_lit", 32'(cur_col_o), 32'd79);
      check("pre_wrap_row_lit", 32'(cur_row_o), 32'd3);
      send(8'h7A, 8'h42);
      wait_ready(200, "wrap");
      check("wrap_col_lit", 32'(cur_col_o), 32'd0);
      check("wrap_row_lit", 32'(cur_row_o), 32'd4);

      // LF from the last row wraps to row 0.
      for (int i = 0; i < 25; i++) send(8'h0A, 8'h00);
      for (int i = 0; i < 10; i++) send(8'h7E, 8'h33);
      wait_ready(200, "pre_lf");
      check("pre_lf_row_lit", 32'(cur_row_o), 32'd29);
      send(8'h0A, 8'h00);
      wait_ready(200, "lf");
      check("lf_row_lit", 32'(cur_row_o), 32'd0);
      check("lf_col_lit", 32'(cur_col_o), 32'd0);

      // CR, BS, BS back-to-back from (2,1).
      send(8'h0A, 8'h00);
      send(8'h0A, 8'h00);
      send(8'h71, 8'h00);
      wait_ready(200, "pre_crbs");
      base = nwr;
      @(negedge clk);
      ch_valid_i = 1'b1; ch_data_i = 8'h0D;
      check("cr_ready", 32'(ch_ready_o), 32'd1);
      model_accept(8'h0D, 8'h00);
      @(negedge clk);
      check("cr_col_now", 32'(cur_col_o), 32'd0);
      ch_data_i = 8'h08;
      check("bs1_ready", 32'(ch_ready_o), 32'd1);
      model_accept(8'h08, 8'h00);
      @(negedge clk);
      ch_data_i = 8'h08;
      check("bs2_ready", 32'(ch_ready_o), 32'd1);
      model_accept(8'h08, 8'h00);
      @(negedge clk);
      ch_valid_i = 1'b0;
      check("crbs_no_writes", 32'(nwr - base), 32'd0);
      check("crbs_col_lit", 32'(cur_col_o), 32'd0);
      check("crbs_row_lit", 32'(cur_row_o), 32'd2);

      // BS with a nonzero column, plus ignored control bytes.
      send(8'h72, 8'h00);
      send(8'h08, 8'h00);
      base = nwr;
      send(8'h01, 8'h00);
      send(8'h7F, 8'h00);
      wait_ready(100, "bs_ign");
      check("ignored_no_writes", 32'(nwr - base), 32'd0);
      check("bs_col_lit", 32'(cur_col_o), 32'd0);

      // Reset during the 100th write of an FF clear.
      send(8'h0C, 8'h00);
      base = nwr;
      begin : ff_wait
         int n;
         n = 0;
         while ((nwr - base) < 100 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
         end
      end
      check("ff_reached_100", 32'(nwr - base), 32'd100);
      rst_i = 1'b0;
      #1;
      check("abort_req", 32'(req_o), 32'd0);
      check("abort_we", 32'(write_enable_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd1);
      check("abort_ready", 32'(ch_ready_o), 32'd0);
      exp_q.delete();
      mrow = 0;
      mcol = 0;
      @(negedge clk);
      @(negedge clk);
      push_all_clear();
      base = nwr;
      rst_i = 1'b1;
      @(negedge clk);
      #1;
      check("restart_req", 32'(req_o), 32'd1);
      check("restart_addr", addr_o, CHAR_BASE);
      wait_ready(2000, "restart");
      check("restart_writes", 32'(nwr - base), 32'd600);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Bus-master text console that sits directly upstream of the VGA system-bus controller. It accepts a byte stream of ASCII characters over a valid/ready handshake, keeps a cursor, and turns each character into single-cycle write transactions into the character map and, optionally, the colour map. It also handles control characters and clears the screen and rows by issuing burst writes of space characters.

## Interface
Parameters:
- COLS, 80, characters per row; must be a multiple of 4.
- ROWS, 30, rows per screen; COLS*ROWS ≤ 4096.
- CHAR_BASE, 32'h0000_0000, byte base address of the character map.
- COL_BASE, 32'h0000_1000, byte base address of the colour map.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset; asynchronous, active-low.
- ch_valid_i  input  1  character available.
- ch_data_i  input  8  ASCII code.
- ch_attr_i  input  8  colour attribute; sampled with the character.
- ch_ready_o  output  1  block can accept a character this cycle.
- req_o  output  1  bus request.
- write_enable_o  output  1  bus write strobe; equals req_o, because the block never reads.
- mem_be_o  output  4  byte enables.
- addr_o  output  32  byte address.
- write_data_o  output  32  write data.
- cur_col_o  output  7  cursor column.
- cur_row_o  output  5  cursor row.
- busy_o  output  1  a clear operation is in progress.

## Operation
- The character byte offset is off = cur_row*COLS + cur_col, and is 12 bits wide.
- Character write:
  - addr_o = CHAR_BASE + {off[11:2],2'b00}.
  - mem_be_o = 4'b0001 << off[1:0].
  - write_data_o = {4{byte}}.
- Attribute write: identical, except the base is COL_BASE.
- Clear write:
  - Word-aligned, mem_be_o = 4'hF, write_data_o = 32'h2020_2020.
  - Applies to the character map only.
- FSM states are IDLE, PUT_CHAR, PUT_ATTR, CLR_ROW and CLR_ALL.
- The handshake completes when ch_valid_i && ch_ready_o.
- ch_ready_o = 1 only in IDLE.
- Accepted byte handling:
  - 0x20–0x7E, printable: go to PUT_CHAR.
  - 0x0A, LF: cur_col := 0 and cur_row := (cur_row+1) mod ROWS, then go to CLR_ROW for the new row.
  - 0x0D, CR: cur_col := 0 and stay in IDLE. There is no bus activity.
  - 0x08, BS: if cur_col > 0, then cur_col := cur_col−1. Stay in IDLE with no bus activity. At cur_col = 0 nothing happens.
  - 0x0C, FF: cursor := (0,0), then go to CLR_ALL.
  - Any other byte is consumed and ignored.
- PUT_CHAR:
  - Issues one character write.
  - Then goes to PUT_ATTR if colour is enabled, otherwise advances the cursor.
- Cursor advance:
  - If cur_col < COLS−1, cur_col++ and return to IDLE.
  - Otherwise cur_col := 0 and cur_row := (cur_row+1) mod ROWS, then go to CLR_ROW. This is wrap-around with no scroll.
- CLR_ROW:
  - Issues COLS/4 clear writes covering row cur_row, word index counting upward.
  - Then returns to IDLE.
- CLR_ALL:
  - Issues COLS*ROWS/4 clear writes starting at word 0.
  - Then returns to IDLE.
- busy_o = 1 in CLR_ROW and CLR_ALL.

## Timing
- All outputs are registered.
- Reset values:
  - req_o = 0, write_enable_o = 0, mem_be_o = 0, addr_o = 0, write_data_o = 0.
  - cur_col_o = 0, cur_row_o = 0.
  - ch_ready_o = 0, busy_o = 1.
  - State is CLR_ALL with the word counter at 0.
- First write after reset: the first clear write appears on the first rising edge after rst_i deasserts. A full power-up clear takes 600 cycles with default parameters, and ch_ready_o rises the following cycle.
- Printable character accepted at edge N:
  - The character write is visible in cycle N+1.
  - With colour enabled, the attribute write is in N+2.
  - ch_ready_o is high again in N+2, or in N+3 with colour enabled.
  - When the write also wraps the line, COLS/4 clear cycles are inserted before ch_ready_o returns.
- CR and BS:
  - The cursor updates at the accept edge.
  - ch_ready_o stays high, so back-to-back CR and BS bytes are accepted every cycle.
- Bus protocol:
  - The downstream slave accepts writes in the same cycle.
  - One write is issued per cycle in which req_o = 1, with no wait states.
  - req_o is never high in IDLE.
- Characters presented while ch_ready_o = 0 are held by the source and are not lost.
- The cursor outputs reflect the state after the last completed edge.
- Reset asserted mid-operation (asynchronously):
  - Any clear in progress is aborted.
  - Any pending character is dropped.
  - A full clear restarts after release.

## Configuration
- TEXT_CONSOLE_COLOR_EN defined:
  - The PUT_ATTR state exists.
  - Every printable character is followed by an attribute write of ch_attr_i at the same offset in COL_BASE.
- Not defined:
  - PUT_ATTR is removed and ch_attr_i is unused.
  - Only the character map is ever written.
  - The printable turnaround is 2 cycles.

## Test plan
- Reset release:
  - Required: exactly 600 writes, at addr 0x000 through 0x95C step 4, each with be F and data 20202020.
  - Required: busy_o falls after the last write, ch_ready_o = 1 and the cursor is (0,0).
- Send 'A' (0x41) at the cursor (0,5):
  - Required: one write with addr CHAR_BASE+0x004, be 4'b0010, data 41414141.
  - Required: the cursor moves to (0,6). With colour enabled, the next cycle writes ch_attr_i to COL_BASE+0x004 with be 4'b0010.
- Cursor at (3,79), send 'z':
  - Required: a character write at offset 319.
  - Required: the cursor becomes (4,0), followed by 20 clear writes at CHAR_BASE+320 through +396.
- Cursor at (29,10), send LF:
  - Required: the cursor becomes (0,0), and row 0 is cleared with 20 writes at 0x000 through 0x04C.
- Send CR, BS, BS back-to-back from cursor (2,1) at 1 char/cycle:
  - Required: all three bytes are accepted with no bus writes, and the final cursor is (2,0).
- Assert rst_i low at the 100th write of an FF clear:
  - Required: req_o drops immediately.
  - Required: after release, the full clear restarts at addr 0 and the cursor is (0,0).
